// File: rtl/iomem_initiator_if.sv
// Command/response port plus PicoSoC iomem bus seen by the initiator.
// master: the initiator (drives iomem requests); slave: command source + iomem responder.
interface iomem_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  rsp_ready, iomem_ready, iomem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output rsp_ready, iomem_ready, iomem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );
endinterface

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: takes one command, runs one iomem transaction,
// returns read data or a timeout response.
module iomem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  iomem_initiator_if.master        bus,
  output logic                     busy,
  output logic [7:0]               timeout_count
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam bit                      TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_WIDTH-1:0] ToLast    = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [TO_CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                    write_q, write_d;
  logic                    valid_q, valid_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rsp_to_q, rsp_to_d;
  logic [7:0]              to_total_q, to_total_d;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    write_d    = write_q;
    valid_d    = valid_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rsp_to_d   = rsp_to_q;
    to_total_d = to_total_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          write_d  = bus.cmd_write;
          valid_d  = 1'b1;
          addr_d   = {bus.cmd_addr[31:2], 2'b00};
          wdata_d  = bus.cmd_wdata;
          wstrb_d  = bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
          to_cnt_d = '0;
          state_d  = StBus;
        end
      end
      StBus: begin
        // Valid must fall on the ready edge or the responder re-triggers.
        if (bus.iomem_ready) begin
          valid_d  = 1'b0;
          rdata_d  = write_q ? 32'h0 : bus.iomem_rdata;
          rsp_to_d = 1'b0;
          state_d  = StResp;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
          if (TimeoutEn && (to_cnt_q == ToLast)) begin
            valid_d  = 1'b0;
            rdata_d  = 32'hFFFF_FFFF;
            rsp_to_d = 1'b1;
            if (to_total_q != 8'hFF) begin
              to_total_d = to_total_q + 8'd1;
            end
            state_d  = StResp;
          end
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_to_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      to_cnt_q   <= '0;
      write_q    <= 1'b0;
      valid_q    <= 1'b0;
      wstrb_q    <= 4'b0000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      rsp_to_q   <= 1'b0;
      to_total_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      write_q    <= write_d;
      valid_q    <= valid_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rsp_to_q   <= rsp_to_d;
      to_total_q <= to_total_d;
    end
  end

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.rsp_valid   = (state_q == StResp);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.iomem_valid = valid_q;
  assign bus.iomem_wstrb = wstrb_q;
  assign bus.iomem_addr  = addr_q;
  assign bus.iomem_wdata = wdata_q;
  assign busy            = (state_q != StIdle);
  assign timeout_count   = to_total_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Self-checking bench: vector table through a 255-cycle-timeout instance, plus
// hand sequences on a 4-cycle-timeout instance for threshold race and saturation.
module tb_iomem_initiator;

  localparam int Never = 1000;

  logic       clk;
  logic       resetn;
  logic       busy, busy4;
  logic [7:0] tocnt, tocnt4;

  iomem_initiator_if bus();
  iomem_initiator_if b4();

  iomem_initiator #(.TIMEOUT_CYCLES(255), .TO_CNT_WIDTH(8)) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .busy          (busy),
    .timeout_count (tocnt)
  );

  iomem_initiator #(.TIMEOUT_CYCLES(4), .TO_CNT_WIDTH(8)) u_dut4 (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (b4),
    .busy          (busy4),
    .timeout_count (tocnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;        // idle cycles before the responder pulses ready
    logic [31:0] rdata;
    int          rsp_wait;   // cycles rsp_ready is held low
    bit          cmd_during; // offer a new command during backpressure
    bit          stray;      // late ready pulse while in RESP
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_vcnt;
    int          exp_edges;
    logic [7:0]  exp_tocnt;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    exp_t e;
    int   vcnt;
    int   edges;
    bit   got;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_wstrb = v.wstrb;
    bus.cmd_valid = 1'b1;
    e.rdata = v.exp_rdata;
    e.to    = v.exp_to;
    sb.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
    chk($sformatf("v%0d_valid_up", idx), 32'(bus.iomem_valid), 1);
    chk($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready), 0);
    chk($sformatf("v%0d_addr", idx), bus.iomem_addr, v.exp_addr);
    chk($sformatf("v%0d_wstrb", idx), 32'(bus.iomem_wstrb), 32'(v.exp_wstrb));
    chk($sformatf("v%0d_wdata", idx), bus.iomem_wdata, v.wdata);
    vcnt  = 0;
    edges = 0;
    got   = 1'b0;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      if (bus.iomem_valid) vcnt++;
      if (cyc == v.lat) begin
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = v.rdata;
      end
      tick();
      bus.iomem_ready = 1'b0;
      bus.iomem_rdata = $urandom;
      got   = bus.rsp_valid;
      edges = cyc + 1;
    end
    chk($sformatf("v%0d_rsp_seen", idx), 32'(got), 1);
    chk($sformatf("v%0d_latency", idx), 32'(edges), 32'(v.exp_edges));
    chk($sformatf("v%0d_valid_cycles", idx), 32'(vcnt), 32'(v.exp_vcnt));
    chk($sformatf("v%0d_valid_down", idx), 32'(bus.iomem_valid), 0);
    for (int w = 0; w < v.rsp_wait; w++) begin
      if (v.stray && w == 2) begin
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'hDEAD_DEAD;
      end
      if (v.cmd_during) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'hAAAA_AAA0;
      end
      tick();
      bus.iomem_ready = 1'b0;
      chk($sformatf("v%0d_hold_valid", idx), 32'(bus.rsp_valid), 1);
      chk($sformatf("v%0d_hold_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_hold_cmd_ready", idx), 32'(bus.cmd_ready), 0);
      chk($sformatf("v%0d_hold_addr", idx), bus.iomem_addr, v.exp_addr);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    e = sb.pop_front();
    chk($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata, e.rdata);
    chk($sformatf("v%0d_rsp_timeout", idx), 32'(bus.rsp_timeout), 32'(e.to));
    tick();
    bus.rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_clear", idx), 32'(bus.rsp_valid), 0);
    chk($sformatf("v%0d_to_clear", idx), 32'(bus.rsp_timeout), 0);
    chk($sformatf("v%0d_idle", idx), 32'(bus.cmd_ready), 1);
    chk($sformatf("v%0d_busy", idx), 32'(busy), 0);
    chk($sformatf("v%0d_addr_kept", idx), bus.iomem_addr, v.exp_addr);
    chk($sformatf("v%0d_tocnt", idx), 32'(tocnt), 32'(v.exp_tocnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   vc;
    bit   got;
    exp_t e;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0; bus.iomem_ready = 1'b0; bus.iomem_rdata = '0;
    b4.cmd_valid = 1'b0; b4.cmd_write = 1'b0; b4.cmd_addr = '0; b4.cmd_wdata = '0;
    b4.cmd_wstrb = '0; b4.rsp_ready = 1'b0; b4.iomem_ready = 1'b0; b4.iomem_rdata = '0;

    vecs[0] = '{1'b1, 32'h0300_0000, 32'h0000_00A5, 4'b0001, 1, 32'h1111_1111, 0, 1'b0, 1'b0,
                32'h0300_0000, 4'b0001, 32'h0, 1'b0, 2, 2, 8'd0};
    vecs[1] = '{1'b0, 32'h0600_0003, 32'h0, 4'b0000, 1, 32'h1234_5678, 0, 1'b0, 1'b0,
                32'h0600_0000, 4'b0000, 32'h1234_5678, 1'b0, 2, 2, 8'd0};
    vecs[2] = '{1'b1, 32'h0000_1006, 32'hDEAD_BEEF, 4'b1111, 0, 32'h5555_5555, 1, 1'b0, 1'b0,
                32'h0000_1004, 4'b1111, 32'h0, 1'b0, 1, 1, 8'd0};
    vecs[3] = '{1'b1, 32'h0000_2000, 32'h0000_0077, 4'b0000, 2, 32'h9999_9999, 0, 1'b0, 1'b0,
                32'h0000_2000, 4'b0000, 32'h0, 1'b0, 3, 3, 8'd0};
    vecs[4] = '{1'b0, 32'h0300_0008, 32'h0, 4'b1111, 5, 32'hCAFE_F00D, 10, 1'b1, 1'b0,
                32'h0300_0008, 4'b0000, 32'hCAFE_F00D, 1'b0, 6, 6, 8'd0};
    vecs[5] = '{1'b0, 32'h0700_0000, 32'h0, 4'b0000, Never, 32'h0, 5, 1'b0, 1'b1,
                32'h0700_0000, 4'b0000, 32'hFFFF_FFFF, 1'b1, 255, 255, 8'd1};
    vecs[6] = '{1'b0, 32'h0300_0004, 32'h0, 4'b0000, 0, 32'h0000_0001, 2, 1'b0, 1'b0,
                32'h0300_0004, 4'b0000, 32'h0000_0001, 1'b0, 1, 1, 8'd1};

    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
    chk("rst_iomem_valid", 32'(bus.iomem_valid), 0);
    chk("rst_iomem_wstrb", 32'(bus.iomem_wstrb), 0);
    chk("rst_iomem_addr", bus.iomem_addr, 0);
    chk("rst_iomem_wdata", bus.iomem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tocnt", 32'(tocnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Reset while a transaction is stuck in BUS.
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0700_0000;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    chk("mid_valid_high", 32'(bus.iomem_valid), 1);
    chk("mid_busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.iomem_valid), 0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tocnt", 32'(tocnt), 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("post_rst_iomem_valid", 32'(bus.iomem_valid), 0);
    end

    // Ready lands exactly on the 4th valid cycle, the timeout threshold.
    b4.cmd_write = 1'b0;
    b4.cmd_addr  = 32'h0300_0010;
    b4.cmd_valid = 1'b1;
    e.rdata = 32'hBEEF_0004;
    e.to    = 1'b0;
    sb.push_back(e);
    tick();
    b4.cmd_valid = 1'b0;
    repeat (3) tick();
    chk("race_valid_high", 32'(b4.iomem_valid), 1);
    b4.iomem_ready = 1'b1;
    b4.iomem_rdata = 32'hBEEF_0004;
    tick();
    b4.iomem_ready = 1'b0;
    e = sb.pop_front();
    chk("race_valid_down", 32'(b4.iomem_valid), 0);
    chk("race_rsp_valid", 32'(b4.rsp_valid), 1);
    chk("race_rdata", b4.rsp_rdata, e.rdata);
    chk("race_timeout", 32'(b4.rsp_timeout), 32'(e.to));
    chk("race_tocnt", 32'(tocnt4), 0);
    b4.rsp_ready = 1'b1;
    tick();
    chk("race_rsp_clear", 32'(b4.rsp_valid), 0);

    // 260 back-to-back timeouts; the counter must stick at 255.
    b4.cmd_addr = 32'h0700_0000;
    for (int k = 1; k <= 260; k++) begin
      b4.cmd_valid = 1'b1;
      tick();
      b4.cmd_valid = 1'b0;
      vc  = 0;
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        if (b4.iomem_valid) vc++;
        tick();
        got = b4.rsp_valid;
      end
      chk("sat_rsp_seen", 32'(got), 1);
      if (k == 1) begin
        chk("sat_valid_cycles", 32'(vc), 4);
        chk("sat_timeout_flag", 32'(b4.rsp_timeout), 1);
        chk("sat_rdata", b4.rsp_rdata, 32'hFFFF_FFFF);
      end
      tick();
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 260)
        chk($sformatf("sat_tocnt_%0d", k), 32'(tocnt4), (k > 255) ? 255 : k);
    end
    b4.rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
